fp_div_share_ctrl: RTL and testbench
====================================

// Module: fp_div_share_ctrl
// PURPOSE
// - Shares one sequential FP divider between N_REQ requesters (cluster cores) in the shared APU.
// - Round-robin arbitration; one division in flight at a time.
// - Owner index and tag held internally; result buffered and routed back to the owner.
// - Divider latency watchdog: an operation that never completes is aborted instead of hanging the cluster.
// PARAMETERS
// N_REQ      4   number of requesters (>=2)
// FP_WIDTH   32  operand/result width
// TAG_WIDTH  4   per-request tag, returned unchanged
// RND_WIDTH  3   rounding-mode width
// STAT_WIDTH 8   divider status-flag width
// TIMEOUT    16  BUSY cycles without div_valid_i before abort (> divider latency)
// PORTS
// clk_i         in  1                  clock
// rst_ni        in  1                  reset, asynchronous, active-low
// req_valid_i   in  N_REQ              request valid, one bit per requester
// req_ready_o   out N_REQ              request accepted (one-hot or zero)
// req_opa_i     in  N_REQ*FP_WIDTH     dividend, requester k at slice k
// req_opb_i     in  N_REQ*FP_WIDTH     divisor
// req_rnd_i     in  N_REQ*RND_WIDTH    rounding mode
// req_tag_i     in  N_REQ*TAG_WIDTH    tag
// div_en_o      out 1                  start pulse to divider
// div_opa_o     out FP_WIDTH           dividend to divider
// div_opb_o     out FP_WIDTH           divisor to divider
// div_rnd_o     out RND_WIDTH          rounding mode to divider
// div_res_i     in  FP_WIDTH           divider result
// div_status_i  in  STAT_WIDTH         divider status
// div_valid_i   in  1                  divider completion pulse
// resp_valid_o  out N_REQ              response valid, one-hot to the owner
// resp_ready_i  in  N_REQ              requester accepts response
// resp_res_o    out FP_WIDTH           shared result bus
// resp_status_o out STAT_WIDTH         shared status bus
// resp_tag_o    out TAG_WIDTH          tag of the returned operation
// resp_err_o    out 1                  response is a timeout abort
// err_o         out 1                  sticky protocol error
// BEHAVIOUR
// Reset:
// - All outputs 0; state IDLE; RR pointer = N_REQ-1, so requester 0 has first priority.
// - Reset mid-operation drops the op; the divider is reset by the same rst_ni.
// FSM states:
// - IDLE: any req_valid_i -> grant = first set bit at or after ptr+1 (mod N_REQ).
//   - Same cycle: req_ready_o[g]=1; div_en_o=1; div_op*/rnd driven combinationally from slice g.
//   - Owner/tag registered; ptr<=g; cnt<=0; -> BUSY.
// - BUSY: cnt increments each cycle; div_en_o=0; req_ready_o=0.
//   - div_valid_i: capture res/status into buffer, resp_err<=0 -> HOLD.
//   - cnt==TIMEOUT-1 with no valid: buffer res='0, status='0, resp_err<=1, err_o<=1 -> HOLD.
// - HOLD: resp_valid_o[owner]=1; buffer outputs stable until handshake.
//   - On resp_ready_i[owner]=1 -> IDLE, or directly to BUSY if a request is pending.
//   - A direct BUSY entry grants, issues and asserts req_ready_o in that same cycle (RR from new ptr).
//   - resp_ready_i of non-owners ignored.
// Latency:
// - Issue at cycle t, div_valid_i at t+L -> resp_valid_o at t+L+1.
// - Minimum request-to-request spacing L+1 cycles.
// Errors (err_o sticky until reset):
// - div_valid_i outside BUSY: ignored, err_o<=1.
// - div_valid_i in the same cycle as the timeout: treated as valid completion, no error.
// Arbitration:
// - req_valid_i may drop before grant; only bits set in the grant cycle count.
// - RR guarantees each requester a grant within N_REQ issues.
// - resp_* buses are 0 when not in HOLD.
// TESTING
// - Reset, req_valid_i=4'b0100, div_valid_i 4 cycles after issue, res=32'h3F000000:
//   req_ready_o=4'b0100 and div_en_o=1 at issue; resp_valid_o=4'b0100 and resp_res_o=32'h3F000000 five cycles after issue.
// - req_valid_i=4'b1111 held, each resp accepted immediately: grants in order 0,1,2,3,0; no requester starved.
// - resp_ready_i[owner]=0 for 10 cycles: resp_* stable, no div_en_o pulse; on ready=1, next request issued in that same cycle.
// - Divider silent: resp_valid_o with resp_err_o=1 and resp_res_o=0 at issue+TIMEOUT+1 (=17); err_o=1 stays set.
// - div_valid_i pulse while IDLE: err_o=1, no resp_valid_o, next request served normally.
// - rst_ni low in BUSY: all outputs 0 asynchronously; after release requester 0 wins against 4'b1001.

Source files
------------

// File: rtl/fp_div_share_ctrl_if.sv
// Bundle of request, divider and response signals around fp_div_share_ctrl.
// The _i/_o suffixes are from the controller's point of view.
//   slave  : used by fp_div_share_ctrl
//   master : used by the requester cluster and divider side (or a testbench)
// Requester, divider and response signals:
//   req_valid_i/req_ready_o       per-requester request handshake
//   req_opa_i/opb_i/rnd_i/tag_i   packed per-requester operands, slice k = requester k
//   div_en_o/div_opa_o/opb_o/rnd_o   issue side of the shared divider
//   div_res_i/div_status_i/div_valid_i   completion side of the shared divider
//   resp_valid_o/resp_ready_i     per-requester response handshake
//   resp_res_o/status_o/tag_o/err_o   shared response buses
//   err_o                         sticky protocol error
interface fp_div_share_ctrl_if #(
    parameter int N_REQ      = 4,
    parameter int FP_WIDTH   = 32,
    parameter int TAG_WIDTH  = 4,
    parameter int RND_WIDTH  = 3,
    parameter int STAT_WIDTH = 8
);
    logic [N_REQ-1:0]           req_valid_i;
    logic [N_REQ-1:0]           req_ready_o;
    logic [N_REQ*FP_WIDTH-1:0]  req_opa_i;
    logic [N_REQ*FP_WIDTH-1:0]  req_opb_i;
    logic [N_REQ*RND_WIDTH-1:0] req_rnd_i;
    logic [N_REQ*TAG_WIDTH-1:0] req_tag_i;
    logic                       div_en_o;
    logic [FP_WIDTH-1:0]        div_opa_o;
    logic [FP_WIDTH-1:0]        div_opb_o;
    logic [RND_WIDTH-1:0]       div_rnd_o;
    logic [FP_WIDTH-1:0]        div_res_i;
    logic [STAT_WIDTH-1:0]      div_status_i;
    logic                       div_valid_i;
    logic [N_REQ-1:0]           resp_valid_o;
    logic [N_REQ-1:0]           resp_ready_i;
    logic [FP_WIDTH-1:0]        resp_res_o;
    logic [STAT_WIDTH-1:0]      resp_status_o;
    logic [TAG_WIDTH-1:0]       resp_tag_o;
    logic                       resp_err_o;
    logic                       err_o;

    modport slave (
        input  req_valid_i, req_opa_i, req_opb_i, req_rnd_i, req_tag_i,
        input  div_res_i, div_status_i, div_valid_i, resp_ready_i,
        output req_ready_o, div_en_o, div_opa_o, div_opb_o, div_rnd_o,
        output resp_valid_o, resp_res_o, resp_status_o, resp_tag_o, resp_err_o, err_o
    );

    modport master (
        output req_valid_i, req_opa_i, req_opb_i, req_rnd_i, req_tag_i,
        output div_res_i, div_status_i, div_valid_i, resp_ready_i,
        input  req_ready_o, div_en_o, div_opa_o, div_opb_o, div_rnd_o,
        input  resp_valid_o, resp_res_o, resp_status_o, resp_tag_o, resp_err_o, err_o
    );
endinterface

// File: rtl/fp_div_share_ctrl.sv
// Shares one sequential FP divider between N_REQ requesters.
// Round-robin arbitration, one division in flight, result buffered until the
// owning requester accepts it. A watchdog aborts a division that never
// completes after TIMEOUT busy cycles and returns a zero result flagged
// resp_err_o.
// Ports:
//   clk_i   clock
//   rst_ni  asynchronous active-low reset (also resets the divider)
//   bus     fp_div_share_ctrl_if.slave: request, divider and response signals
module fp_div_share_ctrl #(
    parameter int N_REQ      = 4,
    parameter int FP_WIDTH   = 32,
    parameter int TAG_WIDTH  = 4,
    parameter int RND_WIDTH  = 3,
    parameter int STAT_WIDTH = 8,
    parameter int TIMEOUT    = 16
) (
    input logic               clk_i,
    input logic               rst_ni,
    fp_div_share_ctrl_if.slave bus
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    logic [1:0]            state_q;
    logic [PTR_W-1:0]      ptr_q;
    logic [PTR_W-1:0]      owner_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [FP_WIDTH-1:0]   res_q;
    logic [STAT_WIDTH-1:0] stat_q;
    logic [TAG_WIDTH-1:0]  tag_q;
    logic                  rerr_q;
    logic                  err_q;

    logic [PTR_W-1:0]      cand;
    logic [PTR_W-1:0]      gnt_idx;
    logic                  gnt_found;
    logic                  owner_ready;
    logic                  issue;
    logic                  in_hold;
    logic [FP_WIDTH-1:0]   sel_opa;
    logic [FP_WIDTH-1:0]   sel_opb;
    logic [RND_WIDTH-1:0]  sel_rnd;
    logic [TAG_WIDTH-1:0]  sel_tag;

    // Round-robin search starting one past the last grant, wrapping at N_REQ.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = ptr_q;
        for (int i = 0; i < N_REQ; i++) begin
            cand = (cand == PTR_W'(N_REQ - 1)) ? '0 : cand + PTR_W'(1);
            if (!gnt_found && bus.req_valid_i[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    always_comb begin
        sel_opa = '0;
        sel_opb = '0;
        sel_rnd = '0;
        sel_tag = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (gnt_idx == PTR_W'(k)) begin
                sel_opa = bus.req_opa_i[k*FP_WIDTH +: FP_WIDTH];
                sel_opb = bus.req_opb_i[k*FP_WIDTH +: FP_WIDTH];
                sel_rnd = bus.req_rnd_i[k*RND_WIDTH +: RND_WIDTH];
                sel_tag = bus.req_tag_i[k*TAG_WIDTH +: TAG_WIDTH];
            end
        end
    end

    assign in_hold     = (state_q == HOLD);
    assign owner_ready = bus.resp_ready_i[owner_q];
    // A new op starts from IDLE, or straight out of HOLD in the handshake
    // cycle. rst_ni gating keeps the combinational outputs at zero while reset
    // is held.
    assign issue = rst_ni && gnt_found &&
                   ((state_q == IDLE) || (in_hold && owner_ready));

    always_comb begin
        bus.req_ready_o = '0;
        if (issue) bus.req_ready_o[gnt_idx] = 1'b1;
        bus.div_en_o  = issue;
        bus.div_opa_o = issue ? sel_opa : '0;
        bus.div_opb_o = issue ? sel_opb : '0;
        bus.div_rnd_o = issue ? sel_rnd : '0;

        bus.resp_valid_o = '0;
        if (in_hold) bus.resp_valid_o[owner_q] = 1'b1;
        bus.resp_res_o    = in_hold ? res_q  : '0;
        bus.resp_status_o = in_hold ? stat_q : '0;
        bus.resp_tag_o    = in_hold ? tag_q  : '0;
        bus.resp_err_o    = in_hold & rerr_q;
        bus.err_o         = err_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            ptr_q   <= PTR_W'(N_REQ - 1);
            owner_q <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            stat_q  <= '0;
            tag_q   <= '0;
            rerr_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            // A completion pulse is only meaningful while an op is in flight.
            if (bus.div_valid_i && (state_q != BUSY)) err_q <= 1'b1;

            case (state_q)
                BUSY: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    // Completion wins over a coincident watchdog expiry.
                    if (bus.div_valid_i) begin
                        res_q   <= bus.div_res_i;
                        stat_q  <= bus.div_status_i;
                        rerr_q  <= 1'b0;
                        state_q <= HOLD;
                    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        res_q   <= '0;
                        stat_q  <= '0;
                        rerr_q  <= 1'b1;
                        err_q   <= 1'b1;
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (owner_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase

            // Issue overrides the HOLD->IDLE step when a request is waiting.
            if (issue) begin
                owner_q <= gnt_idx;
                ptr_q   <= gnt_idx;
                tag_q   <= sel_tag;
                cnt_q   <= '0;
                state_q <= BUSY;
            end
        end
    end
endmodule

// File: tb/tb_fp_div_share_ctrl.sv
// Testbench for fp_div_share_ctrl: requesters, a behavioural divider with
// random latency (or silence), and a response scoreboard checked by an
// independent monitor. Expected grants come from a plain round-robin rule
// over the requests being presented; expected responses are queued at issue.
module tb_fp_div_share_ctrl;
    localparam int N_REQ      = 4;
    localparam int FP_WIDTH   = 32;
    localparam int TAG_WIDTH  = 4;
    localparam int RND_WIDTH  = 3;
    localparam int STAT_WIDTH = 8;
    localparam int TIMEOUT    = 16;

    typedef struct {
        int                    owner;
        logic [TAG_WIDTH-1:0]  tag;
        logic [FP_WIDTH-1:0]   res;
        logic [STAT_WIDTH-1:0] stat;
        logic                  err;
        int                    due;
    } resp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fp_div_share_ctrl_if #(
        .N_REQ(N_REQ), .FP_WIDTH(FP_WIDTH), .TAG_WIDTH(TAG_WIDTH),
        .RND_WIDTH(RND_WIDTH), .STAT_WIDTH(STAT_WIDTH)
    ) bus ();

    fp_div_share_ctrl #(
        .N_REQ(N_REQ), .FP_WIDTH(FP_WIDTH), .TAG_WIDTH(TAG_WIDTH),
        .RND_WIDTH(RND_WIDTH), .STAT_WIDTH(STAT_WIDTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    resp_t sb[$];
    int    glog[$];
    resp_t mon_e;
    logic [N_REQ-1:0] mon_one;

    logic [N_REQ-1:0]     rq_v = '0;
    logic [FP_WIDTH-1:0]  rq_opa [N_REQ];
    logic [FP_WIDTH-1:0]  rq_opb [N_REQ];
    logic [RND_WIDTH-1:0] rq_rnd [N_REQ];
    logic [TAG_WIDTH-1:0] rq_tag [N_REQ];
    logic [N_REQ-1:0]     rsp_rdy = '0;
    int last_gnt = N_REQ - 1;

    int rdy_mode = 0;
    bit auto_rereq = 0, rand_req = 0, silent = 0, silent_rand = 0;
    bit idle_pulse = 0, fix_res_en = 0;
    int fix_lat = 0;
    logic [FP_WIDTH-1:0]   fix_res = '0;
    int cd = 0;
    logic [FP_WIDTH-1:0]   pend_res = '0;
    logic [STAT_WIDTH-1:0] pend_stat = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_ctl"}, 64'({bus.req_ready_o, bus.div_en_o, bus.resp_valid_o,
                                 bus.resp_err_o, bus.err_o}), 64'd0);
        chk({name, "_div"}, 64'({bus.div_opa_o, bus.div_rnd_o}), 64'd0);
        chk({name, "_divb"}, 64'(bus.div_opb_o), 64'd0);
        chk({name, "_resp"}, 64'({bus.resp_res_o, bus.resp_status_o, bus.resp_tag_o}), 64'd0);
    endtask

    task automatic new_req(input int k);
        rq_v[k]   = 1'b1;
        rq_opa[k] = $urandom;
        rq_opb[k] = $urandom;
        rq_rnd[k] = RND_WIDTH'($urandom_range(0, 7));
        rq_tag[k] = TAG_WIDTH'($urandom_range(0, 15));
    endtask

    task automatic apply_bus();
        for (int k = 0; k < N_REQ; k++) begin
            bus.req_opa_i[k*FP_WIDTH +: FP_WIDTH]   = rq_opa[k];
            bus.req_opb_i[k*FP_WIDTH +: FP_WIDTH]   = rq_opb[k];
            bus.req_rnd_i[k*RND_WIDTH +: RND_WIDTH] = rq_rnd[k];
            bus.req_tag_i[k*TAG_WIDTH +: TAG_WIDTH] = rq_tag[k];
        end
        bus.req_valid_i  = rq_v;
        bus.resp_ready_i = rsp_rdy;
    endtask

    // Inputs for the coming cycle, applied just after the rising edge.
    task automatic drive();
        logic dv;
        dv = 1'b0;
        if (cd > 0) begin
            cd--;
            dv = (cd == 0);
        end
        bus.div_res_i    = dv ? pend_res : $urandom;
        bus.div_status_i = dv ? pend_stat : STAT_WIDTH'($urandom);
        if (idle_pulse) begin
            dv = 1'b1;
            idle_pulse = 1'b0;
        end
        bus.div_valid_i = dv;
        for (int k = 0; k < N_REQ; k++) begin
            if (!rq_v[k]) begin
                if (auto_rereq || (rand_req && $urandom_range(0, 3) == 0)) new_req(k);
            end else if (rand_req && $urandom_range(0, 15) == 0) begin
                rq_v[k] = 1'b0;
            end
        end
        case (rdy_mode)
            0:       rsp_rdy = '1;
            1:       rsp_rdy = N_REQ'($urandom);
            default: rsp_rdy = '0;
        endcase
        apply_bus();
    endtask

    // Issue check: one op in flight, the next starts when the pending response
    // is taken; the winner is the first presented request after the last grant.
    task automatic sample_issue();
        logic [N_REQ-1:0] one;
        bit    hs, exp_iss, sil;
        int    g, lat;
        resp_t e;
        hs = (sb.size() > 0) && (sb[0].due <= cyc) && rsp_rdy[sb[0].owner];
        exp_iss = (rq_v != '0) && ((sb.size() == 0) || hs);
        g = -1;
        for (int i = 1; i <= N_REQ; i++)
            if (g < 0 && rq_v[(last_gnt + i) % N_REQ]) g = (last_gnt + i) % N_REQ;
        one = '0;
        if (exp_iss) one[g] = 1'b1;
        chk("div_en", 64'(bus.div_en_o), 64'(exp_iss));
        chk("req_ready", 64'(bus.req_ready_o), 64'(one));
        if (exp_iss && bus.div_en_o) begin
            chk("div_opa", 64'(bus.div_opa_o), 64'(rq_opa[g]));
            chk("div_opb", 64'(bus.div_opb_o), 64'(rq_opb[g]));
            chk("div_rnd", 64'(bus.div_rnd_o), 64'(rq_rnd[g]));
            sil = silent || (silent_rand && $urandom_range(0, 9) == 0);
            e.owner = g;
            e.tag   = rq_tag[g];
            if (sil) begin
                e.res  = '0;
                e.stat = '0;
                e.err  = 1'b1;
                e.due  = cyc + TIMEOUT + 1;
                cd     = 0;
            end else begin
                lat    = (fix_lat > 0) ? fix_lat : $urandom_range(1, TIMEOUT);
                e.res  = fix_res_en ? fix_res : $urandom;
                e.stat = STAT_WIDTH'($urandom);
                e.err  = 1'b0;
                e.due  = cyc + lat + 1;
                cd        = lat;
                pend_res  = e.res;
                pend_stat = e.stat;
            end
            sb.push_back(e);
            rq_v[g]  = 1'b0;
            last_gnt = g;
            glog.push_back(g);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        sample_issue();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic drain(input int limit);
        for (int i = 0; i < limit && (sb.size() > 0 || rq_v != '0); i++) cycle();
        chk("drain", 64'(sb.size()), 64'd0);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        sb.delete();
        glog.delete();
        cd = 0;
        last_gnt = N_REQ - 1;
        rq_v = '0;
        idle_pulse = 0;
        bus.div_valid_i = 1'b0;
        apply_bus();
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;
        drive();
    endtask

    // Response monitor: whatever the DUT presents must match the queue head.
    always begin
        @(negedge clk);
        #2;
        if (sb.size() == 0 || cyc < sb[0].due) begin
            chk("resp_valid_idle", 64'(bus.resp_valid_o), 64'd0);
            chk("resp_bus_idle", 64'({bus.resp_res_o, bus.resp_status_o,
                                      bus.resp_tag_o, bus.resp_err_o}), 64'd0);
        end else begin
            mon_e = sb[0];
            mon_one = '0;
            mon_one[mon_e.owner] = 1'b1;
            chk("resp_valid", 64'(bus.resp_valid_o), 64'(mon_one));
            chk("resp_res", 64'(bus.resp_res_o), 64'(mon_e.res));
            chk("resp_status", 64'(bus.resp_status_o), 64'(mon_e.stat));
            chk("resp_tag", 64'(bus.resp_tag_o), 64'(mon_e.tag));
            chk("resp_err", 64'(bus.resp_err_o), 64'(mon_e.err));
            if (rsp_rdy[mon_e.owner]) void'(sb.pop_front());
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < N_REQ; k++) begin
            rq_opa[k] = '0; rq_opb[k] = '0; rq_rnd[k] = '0; rq_tag[k] = '0;
        end
        bus.div_valid_i = 1'b0;
        bus.div_res_i = '0;
        bus.div_status_i = '0;
        apply_bus();

        // Single request from requester 2, latency 4, fixed result.
        fix_lat = 4; fix_res_en = 1; fix_res = 32'h3F00_0000; rdy_mode = 0;
        apply_reset();
        new_req(2);
        apply_bus();
        drain(40);
        chk("t1_count", 64'(glog.size()), 64'd1);
        if (glog.size() > 0) chk("t1_owner", 64'(glog[0]), 64'd2);
        // Completion on the watchdog's last cycle is still a good result.
        fix_lat = TIMEOUT; fix_res_en = 0;
        new_req(1);
        apply_bus();
        drain(40);
        chk("t1_err_o", 64'(bus.err_o), 64'd0);

        // All four requesting continuously: strict rotation from requester 0.
        fix_lat = 2; auto_rereq = 1;
        apply_reset();
        for (int i = 0; i < 100 && glog.size() < 5; i++) cycle();
        auto_rereq = 0;
        chk("t2_count", 64'(glog.size() >= 5), 64'd1);
        for (int i = 0; i < 5 && i < glog.size(); i++)
            chk("t2_order", 64'(glog[i]), 64'(i % N_REQ));
        drain(100);

        // Owner withholds ready for 10 cycles while another request waits.
        fix_lat = 3; rdy_mode = 2;
        apply_reset();
        new_req(0);
        apply_bus();
        repeat (5) cycle();
        new_req(1);
        apply_bus();
        repeat (10) cycle();
        rdy_mode = 0;
        rsp_rdy = '1;
        apply_bus();
        cycle();
        chk("t3_count", 64'(glog.size()), 64'd2);
        if (glog.size() > 1) chk("t3_second", 64'(glog[1]), 64'd1);
        drain(40);

        // Completion pulse while idle is a protocol error only.
        fix_lat = 0;
        apply_reset();
        chk("t4_err_before", 64'(bus.err_o), 64'd0);
        idle_pulse = 1;
        drive();
        cycle();
        chk("t4_err_set", 64'(bus.err_o), 64'd1);
        new_req(3);
        apply_bus();
        drain(40);
        chk("t4_served", 64'(glog.size()), 64'd1);
        chk("t4_err_sticky", 64'(bus.err_o), 64'd1);

        // Silent divider: watchdog abort.
        apply_reset();
        silent = 1;
        new_req(1);
        apply_bus();
        cycle();
        chk("t5_err_at_issue", 64'(bus.err_o), 64'd0);
        drain(40);
        silent = 0;
        chk("t5_err_set", 64'(bus.err_o), 64'd1);
        repeat (5) cycle();
        chk("t5_err_sticky", 64'(bus.err_o), 64'd1);

        // Random traffic, random ready, occasional silent divider.
        rand_req = 1; rdy_mode = 1; silent_rand = 1;
        apply_reset();
        repeat (400) cycle();
        rand_req = 0; rdy_mode = 0; silent_rand = 0;
        drain(200);

        // Reset in the middle of a busy operation.
        fix_lat = 10; rdy_mode = 0;
        apply_reset();
        for (int k = 0; k < N_REQ; k++) new_req(k);
        apply_bus();
        repeat (3) cycle();
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("rst_busy");
        sb.delete();
        glog.delete();
        cd = 0;
        last_gnt = N_REQ - 1;
        rq_v = '0;
        new_req(0);
        new_req(3);
        apply_bus();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive();
        cycle();
        chk("t6_count", 64'(glog.size()), 64'd1);
        if (glog.size() > 0) chk("t6_winner", 64'(glog[0]), 64'd0);
        drain(60);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
